// File: rtl/pe_arr_pkg.sv
// Shared definitions for the PE array result path: drain FSM state encoding,
// default array geometry and the wavefront wait-length helper.
package pe_arr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } drain_state_t;

    localparam int DEF_ROWS     = 8;
    localparam int DEF_COLS     = 8;
    localparam int DEF_OUTWIDTH = 32;

    // Cycles from the first fire into the array until the last PE result is
    // valid: reduction length plus the skewed wavefront across the array.
    function automatic int wait_len(input int k, input int rows, input int cols,
                                    input int pe_lat);
        return k + rows + cols - 32'sd2 + pe_lat;
    endfunction

endpackage

// File: rtl/pe_arr_drain_buf.sv
// Result snapshot buffer: ROWS entries of one row each, written all at once
// from the flat PE result vector and read back one row at a time.
// Optional macro PE_ARR_DRAIN_RELU_EN clamps negative fields to zero at capture.
module pe_arr_drain_buf
    import pe_arr_pkg::*;
#(
    parameter int ROWS     = DEF_ROWS,
    parameter int COLS     = DEF_COLS,
    parameter int OUTWIDTH = DEF_OUTWIDTH,
    localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                              clk,
    input  logic                              wr_en,
    input  logic [ROWS*COLS*OUTWIDTH-1:0]     wr_data,
    input  logic [RW-1:0]                     rd_row,
    output logic [COLS*OUTWIDTH-1:0]          rd_data
);

    localparam int RB = COLS * OUTWIDTH;

    logic [ROWS*COLS*OUTWIDTH-1:0] cap_s;
    logic [RB-1:0]                 mem_r [ROWS];

    // Field conditioning applied on the way into the buffer
    always_comb begin
        cap_s = wr_data;
`ifdef PE_ARR_DRAIN_RELU_EN
        for (int i = 0; i < ROWS * COLS; i++) begin
            if (wr_data[i*OUTWIDTH + OUTWIDTH - 1]) begin
                cap_s[i*OUTWIDTH +: OUTWIDTH] = '0;
            end else begin
                cap_s[i*OUTWIDTH +: OUTWIDTH] = wr_data[i*OUTWIDTH +: OUTWIDTH];
            end
        end
`endif
    end

    // Parallel snapshot of every row; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int r = 0; r < ROWS; r++) begin
                mem_r[r] <= cap_s[r*RB +: RB];
            end
        end
    end

    assign rd_data = mem_r[rd_row];

endmodule

// File: rtl/pe_arr_drain.sv
// Downstream result collector for the systolic PE array. Waits out the array
// latency after a start, snapshots all results, then streams one row per beat
// over valid/ready so the array is free for the next job.
// Optional macro PE_ARR_DRAIN_RELU_EN (see pe_arr_drain_buf).
module pe_arr_drain
    import pe_arr_pkg::*;
#(
    parameter int ROWS     = DEF_ROWS,
    parameter int COLS     = DEF_COLS,
    parameter int OUTWIDTH = DEF_OUTWIDTH,
    parameter int KW       = 16,
    parameter int PE_LAT   = 1,
    localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [KW-1:0]                 k_len,
    input  logic [ROWS*COLS*OUTWIDTH-1:0] in_res,
    output logic                          busy,
    output logic                          start_err,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [COLS*OUTWIDTH-1:0]      out_data,
    output logic [RW-1:0]                 out_row,
    output logic                          out_last
);

    localparam logic [RW-1:0] LAST_ROW     = RW'(ROWS - 1);
    localparam logic [RW-1:0] PENULT_ROW   = RW'(ROWS - 2);
    localparam logic [RW-1:0] RD_ONE       = RW'(1'b1);
    localparam logic [KW:0]   CNT_ONE      = (KW + 1)'(1'b1);
    localparam logic          LAST_AT_ZERO = (ROWS == 1) ? 1'b1 : 1'b0;

    drain_state_t             state_r, state_nxt_s;
    logic [KW:0]              cnt_r, cnt_nxt_s;
    logic [RW-1:0]            rd_r, rd_nxt_s;
    logic                     busy_r, busy_nxt_s;
    logic                     err_r, err_nxt_s;
    logic                     valid_r, valid_nxt_s;
    logic                     last_r, last_nxt_s;
    logic                     cap_en_s;
    logic [KW:0]              wait_s;
    logic [COLS*OUTWIDTH-1:0] row_s;

    // Extra top bit keeps k_len near its maximum from wrapping
    assign wait_s = (KW + 1)'(wait_len(int'({1'b0, k_len}), ROWS, COLS, PE_LAT));

    // Next-state and output-register decode for the wait/capture/drain sequence
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        rd_nxt_s    = rd_r;
        busy_nxt_s  = busy_r;
        err_nxt_s   = err_r;
        valid_nxt_s = valid_r;
        last_nxt_s  = last_r;
        cap_en_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = WAIT;
                    cnt_nxt_s   = wait_s;
                    rd_nxt_s    = '0;
                    busy_nxt_s  = 1'b1;
                    err_nxt_s   = 1'b0;
                end else begin
                    busy_nxt_s  = 1'b0;
                end
            end
            WAIT: begin
                if (start) begin
                    err_nxt_s = 1'b1;
                end else begin
                    err_nxt_s = err_r;
                end
                if (cnt_r != '0) begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end else begin
                    cap_en_s    = 1'b1;
                    state_nxt_s = DRAIN;
                    rd_nxt_s    = '0;
                    valid_nxt_s = 1'b1;
                    last_nxt_s  = LAST_AT_ZERO;
                end
            end
            DRAIN: begin
                if (start) begin
                    err_nxt_s = 1'b1;
                end else begin
                    err_nxt_s = err_r;
                end
                if (valid_r && out_ready) begin
                    if (rd_r == LAST_ROW) begin
                        state_nxt_s = IDLE;
                        rd_nxt_s    = '0;
                        busy_nxt_s  = 1'b0;
                        valid_nxt_s = 1'b0;
                        last_nxt_s  = 1'b0;
                    end else begin
                        rd_nxt_s   = rd_r + RD_ONE;
                        last_nxt_s = (rd_r == PENULT_ROW);
                    end
                end else begin
                    rd_nxt_s = rd_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = '0;
                rd_nxt_s    = '0;
                busy_nxt_s  = 1'b0;
                valid_nxt_s = 1'b0;
                last_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, counter and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            rd_r    <= '0;
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            rd_r    <= rd_nxt_s;
            busy_r  <= busy_nxt_s;
            err_r   <= err_nxt_s;
            valid_r <= valid_nxt_s;
            last_r  <= last_nxt_s;
        end
    end

    pe_arr_drain_buf #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .OUTWIDTH (OUTWIDTH)
    ) u_buf (
        .clk     (clk),
        .wr_en   (cap_en_s),
        .wr_data (in_res),
        .rd_row  (rd_r),
        .rd_data (row_s)
    );

    // Buffer contents are undefined outside a drain, so data is forced to zero
    assign out_data  = valid_r ? row_s : '0;
    assign out_row   = rd_r;
    assign out_last  = last_r;
    assign out_valid = valid_r;
    assign busy      = busy_r;
    assign start_err = err_r;

endmodule

// File: tb/tb_pe_arr_drain.sv
// Scoreboard bench for pe_arr_drain: the driver predicts each job's first-beat
// cycle and captured rows from its own model; a monitor pops and compares.
module tb_pe_arr_drain;

    localparam int ROWS   = 8;
    localparam int COLS   = 8;
    localparam int OW     = 32;
    localparam int KW     = 16;
    localparam int PE_LAT = 1;
    localparam int N      = ROWS * COLS * OW;
    localparam int RB     = COLS * OW;

    typedef struct {
        logic [RB-1:0] data;
        logic [2:0]    row;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [KW-1:0] k_len;
    logic [N-1:0]  in_res;
    logic          busy, start_err, out_valid, out_last;
    logic          out_ready = 1'b0;
    logic [RB-1:0] out_data;
    logic [2:0]    out_row;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    beats = 0;
    int    rmode = 0;
    beat_t exp_q[$];
    int    rise_q[$];
    bit    expect_idle = 1'b0;
    bit    hold_v = 1'b0;
    bit    prev_v = 1'b0;
    beat_t hold_b;

    pe_arr_drain #(.ROWS(ROWS), .COLS(COLS), .OUTWIDTH(OW), .KW(KW), .PE_LAT(PE_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k_len     (k_len),
        .in_res    (in_res),
        .busy      (busy),
        .start_err (start_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_last  (out_last)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [RB-1:0] act, input logic [RB-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference model: the captured flat vector, reshaped into row beats
    function automatic void push_job(input logic [N-1:0] v);
        beat_t b;
        logic [OW-1:0] f;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                f = v[(r*COLS + c)*OW +: OW];
`ifdef PE_ARR_DRAIN_RELU_EN
                if ($signed(f) < 0) f = '0;
`endif
                b.data[c*OW +: OW] = f;
            end
            b.row  = 3'(r);
            b.last = (r == ROWS - 1);
            exp_q.push_back(b);
        end
    endfunction

    function automatic logic [N-1:0] rand_vec();
        logic [N-1:0] v;
        for (int i = 0; i < ROWS * COLS; i++) v[i*OW +: OW] = $urandom();
        return v;
    endfunction

    function automatic logic [N-1:0] fill_vec(input int kind);
        logic [N-1:0] v;
        for (int i = 0; i < ROWS * COLS; i++) begin
            case (kind)
                0:       v[i*OW +: OW] = OW'(i + 1);
                1:       v[i*OW +: OW] = 32'h0000_DEAD;
                default: v[i*OW +: OW] = (i % 2 == 0) ? 32'hFFFF_FFFE : 32'd5;
            endcase
        end
        return v;
    endfunction

    task automatic monitor();
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 1'b0;
                hold_v = 1'b0;
                expect_idle = 1'b0;
            end else begin
                if (expect_idle) begin
                    chk("idle_valid", RB'(out_valid), RB'(1'b0));
                    chk("idle_busy", RB'(busy), RB'(1'b0));
                    expect_idle = 1'b0;
                end
                if (out_valid && !prev_v) begin
                    if (rise_q.size() == 0) fail_now("rise_unexpected");
                    else chk("rise_cycle", RB'(cyc), RB'(rise_q.pop_front()));
                end
                if (hold_v) begin
                    chk("stall_valid", RB'(out_valid), RB'(1'b1));
                    chk("stall_data", out_data, hold_b.data);
                    chk("stall_row", RB'(out_row), RB'(hold_b.row));
                    chk("stall_last", RB'(out_last), RB'(hold_b.last));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("beat_unexpected");
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", out_data, e.data);
                        chk("beat_row", RB'(out_row), RB'(e.row));
                        chk("beat_last", RB'(out_last), RB'(e.last));
                        expect_idle = e.last;
                    end
                    beats++;
                    hold_v = 1'b0;
                end else if (out_valid) begin
                    hold_v      = 1'b1;
                    hold_b.data = out_data;
                    hold_b.row  = out_row;
                    hold_b.last = out_last;
                end else begin
                    hold_v = 1'b0;
                end
                prev_v = out_valid;
            end
        end
    endtask

    task automatic ready_gen();
        int idx = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (idx % 3 == 0);
                default: out_ready = ($urandom_range(3) != 0);
            endcase
            idx++;
        end
    endtask

    // cap_mode: 0 none, 1 change in_res after capture edge, 2 change just before it
    task automatic run_job(input int k, input logic [N-1:0] vec, input int cap_mode,
                           input logic [N-1:0] alt, input bit early_start, input bit end_start);
        int w, cap, n;
        in_res = vec;
        k_len  = KW'(k);
        start  = 1'b1;
        w      = k + ROWS + COLS - 2 + PE_LAT;
        cap    = cyc + w + 2;
        rise_q.push_back(cap);
        push_job((cap_mode == 2) ? alt : vec);
        @(posedge clk); #1;
        start = 1'b0;
        chk("err_clear", RB'(start_err), RB'(1'b0));
        chk("busy_up", RB'(busy), RB'(1'b1));
        if (early_start) begin
            repeat (4) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            chk("err_set_wait", RB'(start_err), RB'(1'b1));
        end
        if (cap_mode == 1) begin
            while (cyc < cap) begin @(posedge clk); #1; end
            in_res = alt;
        end else if (cap_mode == 2) begin
            while (cyc < cap - 1) begin @(posedge clk); #1; end
            in_res = alt;
        end
        if (end_start) begin
            for (n = 0; n < 2000; n++) begin
                @(negedge clk);
                if (out_valid && out_ready && out_last) break;
            end
            if (n == 2000) fail_now("last_beat_timeout");
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        for (n = 0; n < 3000 && busy; n++) begin @(posedge clk); #1; end
        if (busy) fail_now("job_timeout");
    endtask

    initial begin
        int target, n;
        logic [N-1:0] v;
        rst = 1'b1; start = 1'b0; k_len = '0; in_res = '0;
        fork
            monitor();
            ready_gen();
            begin
                #200000;
                $display("FAIL watchdog expired");
                $fatal(1, "watchdog");
            end
        join_none
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", RB'(out_valid), RB'(1'b0));
        chk("rst_busy", RB'(busy), RB'(1'b0));
        chk("rst_err", RB'(start_err), RB'(1'b0));
        chk("rst_last", RB'(out_last), RB'(1'b0));
        chk("rst_row", RB'(out_row), RB'(1'b0));
        chk("rst_data", out_data, RB'(1'b0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic drain and backpressure with the sequential pattern
        rmode = 0;
        run_job(4, fill_vec(0), 0, '0, 1'b0, 1'b0);
        rmode = 1;
        run_job(4, fill_vec(0), 0, '0, 1'b0, 1'b0);

        // Capture timing: after-edge change ignored, before-edge change taken
        rmode = 0;
        run_job(4, fill_vec(0), 1, fill_vec(1), 1'b0, 1'b0);
        v = rand_vec();
        run_job(6, fill_vec(0), 2, v, 1'b0, 1'b0);

        // Starts while busy are ignored and sticky; next accepted start clears
        run_job(2, rand_vec(), 0, '0, 1'b1, 1'b1);
        chk("err_sticky", RB'(start_err), RB'(1'b1));
        run_job(9, rand_vec(), 0, '0, 1'b0, 1'b0);

        // Reset during the drain discards remaining beats
        v = rand_vec();
        in_res = v; k_len = 16'd3; start = 1'b1;
        rise_q.push_back(cyc + (3 + ROWS + COLS - 2 + PE_LAT) + 2);
        push_job(v);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        target = beats + 4;
        for (n = 0; n < 300 && beats < target; n++) begin @(posedge clk); #1; end
        if (beats < target) fail_now("reset_wait_timeout");
        chk("pre_rst_err", RB'(start_err), RB'(1'b1));
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", RB'(out_valid), RB'(1'b0));
        chk("mid_rst_busy", RB'(busy), RB'(1'b0));
        chk("mid_rst_err", RB'(start_err), RB'(1'b0));
        chk("mid_rst_last", RB'(out_last), RB'(1'b0));
        chk("mid_rst_data", out_data, RB'(1'b0));
        exp_q.delete();
        rise_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_job(0, rand_vec(), 0, '0, 1'b0, 1'b0);

        // Negative fields (clamped only when the ReLU build is selected)
        run_job(1, fill_vec(2), 0, '0, 1'b0, 1'b0);

        // Randomized jobs with random backpressure
        rmode = 2;
        for (int j = 0; j < 6; j++) begin
            run_job(int'($urandom_range(12)), rand_vec(), 0, '0, 1'b0, 1'b0);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("left_beats", RB'(exp_q.size()), RB'(0));
        chk("left_rises", RB'(rise_q.size()), RB'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
